// File: rtl/ram_stream_pkg.sv
// Shared types and width helpers for the RAM stream reader/writer family.
package ram_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Clamped to one bit so a single-word RAM still gets a legal address port.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int len_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ram_addr_wrap_counter.sv
// Loadable RAM address counter that wraps at depth_p-1, so depth need not be a power of two.
module ram_addr_wrap_counter
   import ram_stream_pkg::*;
#(
   parameter int depth_p = 8,
   localparam int aw_lp = addr_width(depth_p)
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             load,
   input  logic [aw_lp-1:0] load_value,
   input  logic             incr,
   output logic [aw_lp-1:0] value
);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (incr) begin
         value <= (value == aw_lp'(depth_p - 1)) ? '0 : value + aw_lp'(1);
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side master for an async-read RAM: takes an (address, length) command and
// streams the words out through a registered ready/valid port with a last marker.
module ram_stream_reader
   import ram_stream_pkg::*;
#(
   parameter int width_p = 8,
   parameter int depth_p = 8,
   localparam int aw_lp = addr_width(depth_p),
   localparam int lw_lp = len_width(depth_p)
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [aw_lp-1:0]   cmd_addr_i,
   input  logic [lw_lp-1:0]   cmd_len_i,
   output logic [aw_lp-1:0]   rd_addr_o,
   input  logic [width_p-1:0] rd_data_i,
   output logic               data_valid_o,
   input  logic               data_ready_i,
   output logic [width_p-1:0] data_o,
   output logic               data_last_o,
   output logic               busy_o
);

   state_t             state_r;
   logic [lw_lp-1:0]   remaining_r;
   logic [aw_lp-1:0]   addr_r;
   logic               cmd_ready_r;
   logic               data_valid_r;
   logic               data_last_r;
   logic [width_p-1:0] data_r;

   logic accept;
   logic start;
   logic load;

   assign accept = cmd_valid_i && cmd_ready_r;
   assign start  = accept && (cmd_len_i != '0);
   // The output register refills whenever it is empty or its beat is leaving this cycle.
   assign load   = (state_r == FETCH) && (!data_valid_r || data_ready_i) && (remaining_r != '0);

   ram_addr_wrap_counter #(
      .depth_p(depth_p)
   ) u_addr (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .load      (start),
      .load_value(cmd_addr_i),
      .incr      (load),
      .value     (addr_r)
   );

   assign rd_addr_o    = addr_r;
   assign cmd_ready_o  = cmd_ready_r;
   assign data_valid_o = data_valid_r;
   assign data_o       = data_r;
   assign data_last_o  = data_last_r;
   assign busy_o       = (state_r != IDLE);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_r      <= IDLE;
         remaining_r  <= '0;
         cmd_ready_r  <= 1'b0;
         data_valid_r <= 1'b0;
         data_last_r  <= 1'b0;
         data_r       <= '0;
      end else begin
         if (load) begin
            data_r       <= rd_data_i;
            data_valid_r <= 1'b1;
            data_last_r  <= (remaining_r == lw_lp'(1));
            remaining_r  <= remaining_r - lw_lp'(1);
         end
         case (state_r)
            IDLE: begin
               cmd_ready_r <= 1'b1;
               if (start) begin
                  remaining_r <= cmd_len_i;
                  cmd_ready_r <= 1'b0;
                  state_r     <= FETCH;
               end
            end
            FETCH: begin
               if (load && (remaining_r == lw_lp'(1))) begin
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if (data_valid_r && data_ready_i) begin
                  data_valid_r <= 1'b0;
                  data_last_r  <= 1'b0;
                  cmd_ready_r  <= 1'b1;
                  state_r      <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Commands outside the RAM range have no defined behaviour.
   assert property (@(posedge clk_i) disable iff (!reset_ni)
      accept |-> ((32'(cmd_addr_i) < depth_p) && (32'(cmd_len_i) <= depth_p)));

endmodule
